alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Sequential, parametrised successor to the team's combinational ALU.
- Registers operands and results behind a valid/ready handshake, so it can sit between pipelined datapath stages.
- Holds a persistent carry flag, which makes multi-word ADC/SBC chains possible.
- Adds a multi-cycle shift-add multiply and a rotate-through-carry.

Parameters:
- WIDTH, 8, operand and result width in bits (must be ≥ 2).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept; transfer happens on an edge with in_valid && in_ready.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- opcode  input  4  operation select.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  registered result.
- z, c, n, v  output  1 each  registered zero/carry/negative/overflow flags.
- busy  output  1  high while a multiply is iterating.

Behaviour:
- Reset (async, any state, including mid-multiply):
  - state = IDLE.
  - y = 0, z = c = n = v = 0, out_valid = 0, busy = 0.
  - Internal carry flag cleared.
  - Any in-flight operation is discarded.
- State machine:
  - IDLE -> DONE on accept of a single-cycle op.
  - IDLE -> MUL on accept of MUL.
  - MUL -> DONE after WIDTH iteration edges.
  - DONE -> IDLE on out_ready && !in_valid.
  - DONE -> DONE or MUL on out_ready && in_valid (back-to-back accept).
- Handshake:
  - in_ready = (state == IDLE) || (state == DONE && out_ready).
  - out_valid = (state == DONE).
  - y and flags stay stable while out_valid && !out_ready.
  - in_valid is ignored while in_ready = 0.
- Latency:
  - Single-cycle ops: result registered on the accept edge; out_valid high in the next cycle (1-cycle latency).
  - MUL: operands latched on the accept edge, one shift-add per edge over WIDTH edges; out_valid high after edge WIDTH (WIDTH+1 cycles); busy high during MUL.
- Opcodes (y is always WIDTH bits; c and v are 0 unless stated):
  - 0000 TSFA: y = a.
  - 0001 INCA: y = a + 1, wraps.
  - 0010 ADD: {c,y} = a + b; v = (a_msb == b_msb) && (y_msb != a_msb).
  - 0011 SUB: {c,y} = a − b, where c = borrow; v = (a_msb != b_msb) && (y_msb != a_msb).
  - 0100 DECA: y = a − 1, wraps.
  - 0101 AND, 0110 OR, 0111 XOR: bitwise a op b.
  - 1000 COMA: y = ~a.
  - 1001 SHRA: arithmetic right shift by 1; c = a[0].
  - 1010 SHLA: logical left shift by 1; c = a[WIDTH−1].
  - 1011 ADC: {c,y} = a + b + cf; v uses the ADD rule.
  - 1100 SBC: {c,y} = a − b − cf; v uses the SUB rule.
  - 1101 MUL: y = low WIDTH bits of a×b (unsigned); c = (high WIDTH bits != 0); v = 0.
  - 1110 ROLA: y = {a[WIDTH−2:0], cf}; c = a[WIDTH−1].
  - 1111 reserved: y = 0.
- Flags for every op: z = (y == 0); n = y[WIDTH−1].
- cf is the internal carry flag:
  - Updated to the new c whenever a result enters DONE, for every opcode, so logic ops clear it.
  - ADC, SBC and ROLA read cf as it stood before their own update.
- Boundaries:
  - Carry/borrow-out is computed over WIDTH+1 bits; nothing truncates before the carry is taken.
  - A back-to-back accept in DONE overwrites y and flags on the same edge the old result is consumed; no bubble is inserted.
  - Opcode and operands are sampled only on the accept edge; changes during MUL have no effect.

Test Plan:
- ADD a=7F, b=01, WIDTH=8 -> next cycle out_valid=1, y=80, n=1, v=1, c=0, z=0.
- ADD FF+01 -> y=00, c=1, z=1; then ADC 00+00 -> y=01, c=0; then SUB 00−01 -> y=FF, c=1; then SBC 05−02 -> y=02, c=0.
- MUL 10×10 -> busy for 8 cycles, out_valid 9 cycles after accept, y=00, c=1, z=1; MUL 0C×0B -> y=84, c=0, n=1.
- Hold out_ready=0 for 5 cycles after an XOR F0^FF -> y=0F steady, in_ready=0, new in_valid ignored; raise out_ready with in_valid (INCA a=0F) -> y=10 next cycle, no bubble.
- Assert rst mid-MUL (cycle 4) -> immediately out_valid=0, busy=0, y=0, all flags 0; next ROLA a=80 -> y=00, c=1 (confirms cf cleared).
- SHRA a=81 -> y=C0, c=1, n=1; SHLA a=81 -> y=02, c=1; opcode 1111 -> y=00, z=1.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential, parametrised ALU with a valid/ready handshake.
//
// Operands and opcode are taken on an edge where in_valid && in_ready. Single
// cycle operations register their result on that same edge; MUL iterates a
// shift-add over WIDTH further edges. The result and flags are held until the
// consumer takes them with out_ready. A persistent carry flag (cf) feeds
// ADC, SBC and ROLA so multi-word arithmetic can be chained.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand/opcode presented
//   in_ready   block can accept this cycle
//   a, b       WIDTH-bit operands
//   opcode     4-bit operation select
//   out_valid  y and flags hold a valid result
//   out_ready  consumer accepts the result
//   y          registered result
//   z,c,n,v    registered zero/carry/negative/overflow flags
//   busy       high while a multiply is iterating
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v,
  output logic             busy
);

  localparam int MSB   = WIDTH - 1;
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_TSFA = 4'b0000;
  localparam logic [3:0] OP_INCA = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_DECA = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_COMA = 4'b1000;
  localparam logic [3:0] OP_SHRA = 4'b1001;
  localparam logic [3:0] OP_SHLA = 4'b1010;
  localparam logic [3:0] OP_ADC  = 4'b1011;
  localparam logic [3:0] OP_SBC  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_ROLA = 4'b1110;
  localparam logic [3:0] OP_RSVD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state_reg;

  logic [WIDTH-1:0]   y_reg;
  logic               z_reg;
  logic               c_reg;
  logic               n_reg;
  logic               v_reg;

  // Multiplier datapath: the multiplicand walks left, the multiplier walks
  // right, and its LSB decides whether the multiplicand is accumulated.
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [2*WIDTH-1:0] acc_next;

  // The carry flag output and the internal cf are the same bit: both are
  // updated exactly when a result enters DONE and are otherwise held.
  logic cf;
  assign cf = c_reg;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic accept;

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == MUL);

  assign y = y_reg;
  assign z = z_reg;
  assign c = c_reg;
  assign n = n_reg;
  assign v = v_reg;

  // -------------------------------------------------------------------------
  // Bitwise unit
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] or_bits;
  logic [WIDTH-1:0] xor_bits;
  logic [WIDTH-1:0] com_bits;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
      assign and_bits[gi] = a[gi] & b[gi];
      assign or_bits[gi]  = a[gi] | b[gi];
      assign xor_bits[gi] = a[gi] ^ b[gi];
      assign com_bits[gi] = ~a[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Adder / subtractor, evaluated over WIDTH+1 bits so the carry or borrow
  // lands in bit WIDTH. For subtraction the full range a-b-1 >= -2^WIDTH
  // still fits, so bit WIDTH is the borrow.
  // -------------------------------------------------------------------------
  logic             add_cin;
  logic             sub_bin;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             add_ovf;
  logic             sub_ovf;

  assign add_cin  = (opcode == OP_ADC) && cf;
  assign sub_bin  = (opcode == OP_SBC) && cf;
  assign sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
  assign diff_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_bin};
  assign add_ovf  = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
  assign sub_ovf  = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);

  // -------------------------------------------------------------------------
  // Single-cycle result selection
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;
  logic             alu_z;
  logic             alu_n;

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (opcode)
      OP_TSFA: alu_y = a;
      OP_INCA: alu_y = a + 1'b1;
      OP_ADD: begin
        alu_y = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
        alu_v = add_ovf;
      end
      OP_SUB: begin
        alu_y = diff_ext[WIDTH-1:0];
        alu_c = diff_ext[WIDTH];
        alu_v = sub_ovf;
      end
      OP_DECA: alu_y = a - 1'b1;
      OP_AND:  alu_y = and_bits;
      OP_OR:   alu_y = or_bits;
      OP_XOR:  alu_y = xor_bits;
      OP_COMA: alu_y = com_bits;
      OP_SHRA: begin
        alu_y = {a[MSB], a[MSB:1]};
        alu_c = a[0];
      end
      OP_SHLA: begin
        alu_y = {a[MSB-1:0], 1'b0};
        alu_c = a[MSB];
      end
      OP_ADC: begin
        alu_y = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
        alu_v = add_ovf;
      end
      OP_SBC: begin
        alu_y = diff_ext[WIDTH-1:0];
        alu_c = diff_ext[WIDTH];
        alu_v = sub_ovf;
      end
      OP_MUL:  alu_y = '0;  // handled by the iterative path
      OP_ROLA: begin
        alu_y = {a[MSB-1:0], cf};
        alu_c = a[MSB];
      end
      OP_RSVD: alu_y = '0;
      default: alu_y = '0;
    endcase
  end

  assign alu_z = (alu_y == '0);
  assign alu_n = alu_y[MSB];

  // One shift-add step of the multiplier.
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // -------------------------------------------------------------------------
  // Control FSM and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      y_reg      <= '0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
      n_reg      <= 1'b0;
      v_reg      <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            if (opcode == OP_MUL) begin
              // Operands are captured here; later changes on a/b/opcode
              // cannot reach the multiplier.
              mcand_reg  <= {{WIDTH{1'b0}}, a};
              mplier_reg <= b;
              acc_reg    <= '0;
              count_reg  <= '0;
              state_reg  <= MUL;
            end else begin
              // Back-to-back accept in DONE overwrites the consumed result
              // on this same edge, so no bubble appears.
              y_reg     <= alu_y;
              c_reg     <= alu_c;
              v_reg     <= alu_v;
              z_reg     <= alu_z;
              n_reg     <= alu_n;
              state_reg <= DONE;
            end
          end else if ((state_reg == DONE) && out_ready) begin
            state_reg <= IDLE;
          end
        end

        MUL: begin
          acc_reg    <= acc_next;
          mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
          mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
          count_reg  <= count_reg + 1'b1;
          if (count_reg == LAST_ITER) begin
            // acc_next already holds the full 2*WIDTH-bit product.
            y_reg     <= acc_next[WIDTH-1:0];
            c_reg     <= |acc_next[2*WIDTH-1:WIDTH];
            v_reg     <= 1'b0;
            z_reg     <= (acc_next[WIDTH-1:0] == '0);
            n_reg     <= acc_next[WIDTH-1];
            state_reg <= DONE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH = 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam logic [3:0] OP_INCA = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SHRA = 4'b1001;
  localparam logic [3:0] OP_SHLA = 4'b1010;
  localparam logic [3:0] OP_ADC  = 4'b1011;
  localparam logic [3:0] OP_SBC  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_ROLA = 4'b1110;
  localparam logic [3:0] OP_RSVD = 4'b1111;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       z;
  logic       c;
  logic       n;
  logic       v;
  logic       busy;

  int tests_run;
  int tests_failed;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .z         (z),
    .c         (c),
    .n         (n),
    .v         (v),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] ey,
                           input logic ec, input logic ez, input logic en, input logic ev);
    $display("[TB] %s: out_valid=%0b y=%h c=%0b z=%0b n=%0b v=%0b",
             tag, out_valid, y, c, z, n, v);
    check({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".y"}, {24'b0, y}, {24'b0, ey});
    check({tag, ".c"}, {31'b0, c}, {31'b0, ec});
    check({tag, ".z"}, {31'b0, z}, {31'b0, ez});
    check({tag, ".n"}, {31'b0, n}, {31'b0, en});
    check({tag, ".v"}, {31'b0, v}, {31'b0, ev});
  endtask

  // Present one operation for a single cycle; returns at the falling edge
  // right after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb);
    @(negedge clk);
    check("issue.in_ready", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    opcode    = op;
    a         = aa;
    b         = bb;
    out_ready = 1'b1;
    $display("[TB] issue op=%b a=%h b=%h", op, aa, bb);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count busy samples and the sample index at which out_valid appears,
  // starting from the first falling edge after the MUL accept (index 1).
  task automatic wait_mul(output int busy_cnt, output int lat);
    busy_cnt = 0;
    lat      = 1;
    opcode   = OP_ADD;   // scramble inputs: must not affect the multiply
    a        = 8'hFF;
    b        = 8'hFF;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      if (busy) busy_cnt++;
      if (i == 2) check("mul.in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    check("mul.done_seen", {31'b0, out_valid}, 32'd1);
  endtask

  initial begin
    int bcnt;
    int lat;
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 8'h00;
    b         = 8'h00;
    opcode    = 4'h0;

    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.busy",      {31'b0, busy},      32'd0);
    check("rst.in_ready",  {31'b0, in_ready},  32'd1);
    check("rst.y",         {24'b0, y},         32'd0);
    check("rst.flags",     {28'b0, z, c, n, v}, 32'd0);
    rst = 1'b0;

    // Signed overflow on ADD.
    issue(OP_ADD, 8'h7F, 8'h01);
    check_res("add_7f_01", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);

    // Carry chain: ADD -> ADC -> SUB -> SBC.
    issue(OP_ADD, 8'hFF, 8'h01);
    check_res("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(OP_ADC, 8'h00, 8'h00);
    check_res("adc_00_00", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_SUB, 8'h00, 8'h01);
    check_res("sub_00_01", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(OP_SBC, 8'h05, 8'h02);
    check_res("sbc_05_02", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

    // Multiply with high half nonzero.
    issue(OP_MUL, 8'h10, 8'h10);
    wait_mul(bcnt, lat);
    check("mul1.busy_cycles", bcnt, 32'd8);
    check("mul1.latency", lat, 32'd9);
    check_res("mul_10_10", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    issue(OP_MUL, 8'h0C, 8'h0B);
    wait_mul(bcnt, lat);
    check("mul2.busy_cycles", bcnt, 32'd8);
    check_res("mul_0c_0b", 8'h84, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: result held, new requests ignored, then no-bubble accept.
    @(negedge clk);
    check("xor.in_ready", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    opcode    = OP_XOR;
    a         = 8'hF0;
    b         = 8'hFF;
    out_ready = 1'b0;
    $display("[TB] issue op=%b a=%h b=%h (out_ready low)", OP_XOR, 8'hF0, 8'hFF);
    @(negedge clk);
    opcode = OP_INCA;
    a      = 8'h33;
    for (int i = 0; i < 5; i++) begin
      $display("[TB] hold cycle %0d: y=%h in_ready=%0b", i, y, in_ready);
      check("hold.y",         {24'b0, y},         32'h0F);
      check("hold.in_ready",  {31'b0, in_ready},  32'd0);
      check("hold.out_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
    end
    a         = 8'h0F;
    out_ready = 1'b1;
    $display("[TB] issue op=%b a=%h (back-to-back)", OP_INCA, 8'h0F);
    @(negedge clk);
    in_valid = 1'b0;
    check_res("inca_0f_b2b", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);

    // Shifts and the reserved opcode.
    issue(OP_RSVD, 8'h5A, 8'hA5);
    check_res("rsvd", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(OP_SHRA, 8'h81, 8'h00);
    check_res("shra_81", 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(OP_SHLA, 8'h81, 8'h00);
    check_res("shla_81", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a multiply (cf is 1 before it).
    issue(OP_MUL, 8'h03, 8'h05);
    repeat (3) @(negedge clk);
    check("pre_rst.busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("[TB] async reset mid-MUL: busy=%0b out_valid=%0b y=%h", busy, out_valid, y);
    check("midrst.out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst.busy",      {31'b0, busy},      32'd0);
    check("midrst.y",         {24'b0, y},         32'd0);
    check("midrst.flags",     {28'b0, z, c, n, v}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ROLA after reset sees cf = 0; a second ROLA sees cf = 1.
    issue(OP_ROLA, 8'h80, 8'h00);
    check_res("rola_80", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(OP_ROLA, 8'h01, 8'h00);
    check_res("rola_01_cf1", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
